// File: rtl/vram_port_arbiter_if.sv
// VRAM port arbiter bus: three requester channels plus the memory wrapper port.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requesters and models the memory.
interface vram_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic              r_gnt;
    logic              r_rvalid;

    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;

    logic [DATA_W-1:0] rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  r_req, r_addr,
        input  c_req, c_we, c_addr, c_wdata,
        input  l_req, l_we, l_addr, l_wdata,
        input  mem_rdata,
        output r_gnt, r_rvalid, c_gnt, c_rvalid, l_gnt, l_rvalid,
        output rdata, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output r_req, r_addr,
        output c_req, c_we, c_addr, c_wdata,
        output l_req, l_we, l_addr, l_wdata,
        output mem_rdata,
        input  r_gnt, r_rvalid, c_gnt, c_rvalid, l_gnt, l_rvalid,
        input  rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares the PPU VRAM port between the renderer (absolute
// priority), CPU PPUDATA accesses and the bulk CHR/nametable loader. CPU and
// loader alternate, with the loader allowed up to LOADER_BURST grants in a row.
// Optional per-requester stall counters are built when VRAM_ARB_STATS_EN is
// defined; arbitration is identical either way.
module vram_port_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 8,
    parameter int LOADER_BURST = 16
) (
    input  logic        clk,
    input  logic        rst,
`ifdef VRAM_ARB_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] stat_stall_cpu,
    output logic [15:0] stat_stall_ldr,
`endif
    vram_port_arbiter_if.slave bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [7:0] BURST_MAX = 8'(LOADER_BURST);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    // 1 = CPU owned the port last among CPU/loader; reset favours the CPU.
    logic        last_cpu_q, last_cpu_d;

    logic        r_gnt, c_gnt, l_gnt;
    logic        r_rvalid_q, c_rvalid_q, l_rvalid_q;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    // CPU/loader fairness state; renderer-only cycles leave it untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_cpu_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_cpu_q <= last_cpu_d;
        end
    end

    // Pick this cycle's winner and the fairness next state
    always_comb begin
        r_gnt      = 1'b0;
        c_gnt      = 1'b0;
        l_gnt      = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_cpu_d = last_cpu_q;

        if (bus.r_req) begin
            r_gnt = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.l_req && (last_cpu_q || !bus.c_req)) begin
                        l_gnt   = 1'b1;
                        cnt_d   = 8'd1;
                        state_d = ST_BURST;
                    end else if (bus.c_req) begin
                        c_gnt      = 1'b1;
                        last_cpu_d = 1'b1;
                    end
                end
                ST_BURST: begin
                    if (bus.l_req && (cnt_q < BURST_MAX)) begin
                        l_gnt = 1'b1;
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        // Burst over: spend one idle cycle handing the turn back.
                        last_cpu_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Drive the memory port from the winner; renderer never writes
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (r_gnt) begin
            mem_addr = bus.r_addr;
        end else if (c_gnt) begin
            mem_addr  = bus.c_addr;
            mem_we    = bus.c_we;
            mem_wdata = bus.c_wdata;
        end else if (l_gnt) begin
            mem_addr  = bus.l_addr;
            mem_we    = bus.l_we;
            mem_wdata = bus.l_wdata;
        end
    end

    // Read data returns one cycle after issue; reset drops in-flight reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid_q <= 1'b0;
            c_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
        end else begin
            r_rvalid_q <= r_gnt;
            c_rvalid_q <= c_gnt && !bus.c_we;
            l_rvalid_q <= l_gnt && !bus.l_we;
        end
    end

    assign bus.r_gnt     = r_gnt;
    assign bus.c_gnt     = c_gnt;
    assign bus.l_gnt     = l_gnt;
    assign bus.r_rvalid  = r_rvalid_q;
    assign bus.c_rvalid  = c_rvalid_q;
    assign bus.l_rvalid  = l_rvalid_q;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_we    = mem_we;
    assign bus.mem_wdata = mem_wdata;

`ifdef VRAM_ARB_STATS_EN
    logic [1:0] stall_req;
    logic [1:0] stall_gnt;
    assign stall_req = {bus.l_req, c_gnt ? 1'b1 : bus.c_req};
    assign stall_gnt = {l_gnt, c_gnt};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stall
            logic [15:0] stall_q;
            // Count waiting cycles, saturating; clear wins over increment
            always_ff @(posedge clk) begin
                if (rst || stat_clr) begin
                    stall_q <= '0;
                end else if (stall_req[gi] && !stall_gnt[gi] && (stall_q != 16'hFFFF)) begin
                    stall_q <= stall_q + 16'd1;
                end
            end
        end
    endgenerate

    assign stat_stall_cpu = g_stall[0].stall_q;
    assign stat_stall_ldr = g_stall[1].stall_q;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter (LOADER_BURST=4). Read returns are
// scoreboarded: expected {requester, data} entries are queued when a read is
// driven and popped when an rvalid appears. Define VRAM_ARB_STATS_EN to also
// exercise the stall counters.
`timescale 1ns/1ps
module tb_vram_port_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int LB     = 4;

    localparam logic [2:0] G_R = 3'b100;
    localparam logic [2:0] G_C = 3'b010;
    localparam logic [2:0] G_L = 3'b001;
    localparam logic [2:0] G_N = 3'b000;

    typedef struct packed {
        logic [2:0] who;
        logic [7:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst;
    int   checks;
    int   failures;
    rd_t  sb_q[$];
    logic [7:0] mem [0:16383];

    always #5 clk = ~clk;

    vram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef VRAM_ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_stall_cpu;
    logic [15:0] stat_stall_ldr;
`endif

    vram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOADER_BURST(LB)) dut (
        .clk(clk),
        .rst(rst),
`ifdef VRAM_ARB_STATS_EN
        .stat_clr(stat_clr),
        .stat_stall_cpu(stat_stall_cpu),
        .stat_stall_ldr(stat_stall_ldr),
`endif
        .bus(bus)
    );

    // VRAM model: one-cycle read latency, write on mem_we
    always @(posedge clk) begin
        bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic idle_inputs();
        bus.r_req = 0; bus.r_addr = '0;
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.l_req = 0; bus.l_we = 0; bus.l_addr = '0; bus.l_wdata = '0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({bus.r_gnt, bus.c_gnt, bus.l_gnt, bus.r_rvalid, bus.c_rvalid, bus.l_rvalid} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs gnt/rvalid=%b expected 000000",
                     {bus.r_gnt, bus.c_gnt, bus.l_gnt, bus.r_rvalid, bus.c_rvalid, bus.l_rvalid});
        end
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 14'h0 || bus.mem_wdata !== 8'h0) begin
            failures++;
            $display("FAIL reset_mem we=%b addr=%h wdata=%h expected 0/0000/00",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
`ifdef VRAM_ARB_STATS_EN
        checks++;
        if (stat_stall_cpu !== 16'h0 || stat_stall_ldr !== 16'h0) begin
            failures++;
            $display("FAIL reset_stats cpu=%h ldr=%h expected 0000/0000", stat_stall_cpu, stat_stall_ldr);
        end
`endif
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checks++;
        if ({bus.r_gnt, bus.c_gnt, bus.l_gnt} !== G_N) begin
            failures++;
            $display("FAIL reset_idle gnt=%b expected %b", {bus.r_gnt, bus.c_gnt, bus.l_gnt}, G_N);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_read();
        logic [2:0] rv;
        rd_t ex;
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 14'h2005;
        sb_q.push_back('{who: G_C, data: 8'hA7});
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.r_gnt, bus.c_gnt, bus.l_gnt} !== ((k == 0) ? G_C : G_N)) begin
                failures++;
                $display("FAIL cpu_read_gnt cyc=%0d gnt=%b expected %b", k,
                         {bus.r_gnt, bus.c_gnt, bus.l_gnt}, (k == 0) ? G_C : G_N);
            end
            if (k == 0) begin
                checks++;
                if (bus.mem_addr !== 14'h2005 || bus.mem_we !== 1'b0) begin
                    failures++;
                    $display("FAIL cpu_read_mem addr=%h we=%b expected 2005/0", bus.mem_addr, bus.mem_we);
                end
            end
            rv = {bus.r_rvalid, bus.c_rvalid, bus.l_rvalid};
            if (rv !== G_N) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL cpu_read_rvalid unexpected rvalid=%b", rv);
                end else begin
                    ex = sb_q.pop_front();
                    if (rv !== ex.who || bus.rdata !== ex.data) begin
                        failures++;
                        $display("FAIL cpu_read_rvalid rvalid=%b rdata=%h expected %b/%h", rv, bus.rdata, ex.who, ex.data);
                    end
                end
            end
            @(posedge clk); #1;
            bus.c_req = 0;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL cpu_read_missing pending=%0d expected 0", sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_render_vs_cpu();
        logic [2:0] rv;
        logic [2:0] exp_g;
        rd_t ex;
        bus.c_we = 1; bus.c_addr = 14'h2006; bus.c_wdata = 8'h3C;
        for (int k = 0; k < 5; k++) begin
            bus.r_req  = (k < 3);
            bus.r_addr = 14'(14'h0100 + k);
            bus.c_req  = (k <= 3);
            if (k < 3) sb_q.push_back('{who: G_R, data: mem[14'h0100 + k]});
            exp_g = (k < 3) ? G_R : ((k == 3) ? G_C : G_N);
            @(negedge clk);
            checks++;
            if ({bus.r_gnt, bus.c_gnt, bus.l_gnt} !== exp_g) begin
                failures++;
                $display("FAIL rend_cpu_gnt cyc=%0d gnt=%b expected %b", k, {bus.r_gnt, bus.c_gnt, bus.l_gnt}, exp_g);
            end
            if (k < 3) begin
                checks++;
                if (bus.mem_we !== 1'b0 || bus.mem_addr !== 14'(14'h0100 + k)) begin
                    failures++;
                    $display("FAIL rend_cpu_rmem cyc=%0d we=%b addr=%h expected 0/%h", k, bus.mem_we, bus.mem_addr, 14'(14'h0100 + k));
                end
            end else if (k == 3) begin
                checks++;
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== 14'h2006 || bus.mem_wdata !== 8'h3C) begin
                    failures++;
                    $display("FAIL rend_cpu_wmem we=%b addr=%h wdata=%h expected 1/2006/3c", bus.mem_we, bus.mem_addr, bus.mem_wdata);
                end
            end
            rv = {bus.r_rvalid, bus.c_rvalid, bus.l_rvalid};
            if (rv !== G_N) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL rend_cpu_rvalid cyc=%0d unexpected rvalid=%b", k, rv);
                end else begin
                    ex = sb_q.pop_front();
                    if (rv !== ex.who || bus.rdata !== ex.data) begin
                        failures++;
                        $display("FAIL rend_cpu_rvalid cyc=%0d rvalid=%b rdata=%h expected %b/%h", k, rv, bus.rdata, ex.who, ex.data);
                    end
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL rend_cpu_missing pending=%0d expected 0", sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_loader_burst();
        logic [2:0] exp_seq [0:12];
        int ld_n;
        int cpu_n;
        exp_seq = '{G_C, G_L, G_L, G_L, G_L, G_N, G_C, G_L, G_L, G_L, G_L, G_N, G_C};
        ld_n = 0;
        cpu_n = 0;
        pulse_reset();
        for (int k = 0; k < 13; k++) begin
            bus.c_req = 1; bus.c_we = 1; bus.c_addr = 14'(14'h3000 + cpu_n); bus.c_wdata = 8'(8'h11 + cpu_n);
            bus.l_req = 1; bus.l_we = 1; bus.l_addr = 14'(ld_n);            bus.l_wdata = 8'(8'h80 + ld_n);
            @(negedge clk);
            checks++;
            if ({bus.r_gnt, bus.c_gnt, bus.l_gnt} !== exp_seq[k]) begin
                failures++;
                $display("FAIL burst_gnt cyc=%0d gnt=%b expected %b", k, {bus.r_gnt, bus.c_gnt, bus.l_gnt}, exp_seq[k]);
            end
            if (exp_seq[k] == G_L) begin
                checks++;
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== 14'(ld_n) || bus.mem_wdata !== 8'(8'h80 + ld_n)) begin
                    failures++;
                    $display("FAIL burst_mem cyc=%0d we=%b addr=%h wdata=%h expected 1/%h/%h", k,
                             bus.mem_we, bus.mem_addr, bus.mem_wdata, 14'(ld_n), 8'(8'h80 + ld_n));
                end
            end
            checks++;
            if ({bus.r_rvalid, bus.c_rvalid, bus.l_rvalid} !== G_N) begin
                failures++;
                $display("FAIL burst_rvalid cyc=%0d rvalid=%b expected 000", k, {bus.r_rvalid, bus.c_rvalid, bus.l_rvalid});
            end
            if (bus.l_gnt) ld_n++;
            if (bus.c_gnt) cpu_n++;
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_render_steal();
        logic [2:0] exp_seq [0:9];
        logic [2:0] rv;
        rd_t ex;
        int ld_n;
        int l_count;
        exp_seq = '{G_C, G_L, G_L, G_R, G_R, G_L, G_L, G_N, G_C, G_L};
        ld_n = 16;
        l_count = 0;
        pulse_reset();
        for (int k = 0; k < 10; k++) begin
            bus.r_req  = (k == 3 || k == 4);
            bus.r_addr = 14'(14'h0200 + k);
            if (bus.r_req) sb_q.push_back('{who: G_R, data: mem[14'h0200 + k]});
            bus.c_req = 1; bus.c_we = 1; bus.c_addr = 14'h3100; bus.c_wdata = 8'h22;
            bus.l_req = 1; bus.l_we = 1; bus.l_addr = 14'(ld_n); bus.l_wdata = 8'(ld_n);
            @(negedge clk);
            checks++;
            if ({bus.r_gnt, bus.c_gnt, bus.l_gnt} !== exp_seq[k]) begin
                failures++;
                $display("FAIL steal_gnt cyc=%0d gnt=%b expected %b", k, {bus.r_gnt, bus.c_gnt, bus.l_gnt}, exp_seq[k]);
            end
            rv = {bus.r_rvalid, bus.c_rvalid, bus.l_rvalid};
            if (rv !== G_N) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL steal_rvalid cyc=%0d unexpected rvalid=%b", k, rv);
                end else begin
                    ex = sb_q.pop_front();
                    if (rv !== ex.who || bus.rdata !== ex.data) begin
                        failures++;
                        $display("FAIL steal_rvalid cyc=%0d rvalid=%b rdata=%h expected %b/%h", k, rv, bus.rdata, ex.who, ex.data);
                    end
                end
            end
            if (bus.l_gnt) begin
                ld_n++;
                if (k >= 1 && k <= 7) l_count++;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        checks++;
        if (l_count != LB) begin
            failures++;
            $display("FAIL steal_burst_len loader_grants=%0d expected %0d", l_count, LB);
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL steal_missing pending=%0d expected 0", sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        logic [2:0] exp_seq [0:7];
        logic [2:0] rv;
        rd_t ex;
        exp_seq = '{G_C, G_L, G_L, G_N, G_N, G_C, G_L, G_N};
        pulse_reset();
        for (int k = 0; k < 8; k++) begin
            bus.c_req  = (k == 0 || k == 5);
            bus.c_we   = 0;
            bus.c_addr = 14'h2005;
            bus.l_req  = (k <= 3 || k == 5 || k == 6);
            bus.l_we   = 0;
            bus.l_addr = (k <= 3) ? 14'(14'h0040 + k - ((k > 0) ? 1 : 0)) : 14'h0043;
            rst        = (k == 3);
            if (exp_seq[k] == G_C) sb_q.push_back('{who: G_C, data: 8'hA7});
            if (exp_seq[k] == G_L) sb_q.push_back('{who: G_L, data: mem[bus.l_addr]});
            @(negedge clk);
            if (k != 3) begin
                checks++;
                if ({bus.r_gnt, bus.c_gnt, bus.l_gnt} !== exp_seq[k]) begin
                    failures++;
                    $display("FAIL rst_burst_gnt cyc=%0d gnt=%b expected %b", k, {bus.r_gnt, bus.c_gnt, bus.l_gnt}, exp_seq[k]);
                end
            end
            rv = {bus.r_rvalid, bus.c_rvalid, bus.l_rvalid};
            if (k == 4) begin
                checks++;
                if (rv !== G_N) begin
                    failures++;
                    $display("FAIL rst_burst_drop rvalid=%b expected 000", rv);
                end
            end else if (rv !== G_N) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL rst_burst_rvalid cyc=%0d unexpected rvalid=%b", k, rv);
                end else begin
                    ex = sb_q.pop_front();
                    if (rv !== ex.who || bus.rdata !== ex.data) begin
                        failures++;
                        $display("FAIL rst_burst_rvalid cyc=%0d rvalid=%b rdata=%h expected %b/%h", k, rv, bus.rdata, ex.who, ex.data);
                    end
                end
            end
            @(posedge clk); #1;
        end
        rst = 0;
        idle_inputs();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL rst_burst_missing pending=%0d expected 0", sb_q.size());
        end
        sb_q.delete();
    endtask

`ifdef VRAM_ARB_STATS_EN
    task automatic test_stats();
        pulse_reset();
        stat_clr = 0;
        bus.c_we = 1; bus.c_addr = 14'h2007; bus.c_wdata = 8'h55;
        for (int k = 0; k < 6; k++) begin
            bus.r_req = (k < 5);
            bus.c_req = 1;
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (stat_stall_cpu !== 16'd5 || stat_stall_ldr !== 16'd0) begin
            failures++;
            $display("FAIL stats_block5 cpu=%0d ldr=%0d expected 5/0", stat_stall_cpu, stat_stall_ldr);
        end
        @(posedge clk); #1;
        stat_clr = 1; bus.r_req = 1; bus.c_req = 1;
        @(posedge clk); #1;
        stat_clr = 0; bus.r_req = 0;
        @(negedge clk);
        checks++;
        if (stat_stall_cpu !== 16'd0) begin
            failures++;
            $display("FAIL stats_clear cpu=%0d expected 0", stat_stall_cpu);
        end
        @(posedge clk); #1;
        bus.r_req = 1; bus.c_req = 1; bus.l_req = 1; bus.l_we = 1;
        repeat (70000) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (stat_stall_cpu !== 16'hFFFF || stat_stall_ldr !== 16'hFFFF) begin
            failures++;
            $display("FAIL stats_saturate cpu=%h ldr=%h expected ffff/ffff", stat_stall_cpu, stat_stall_ldr);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i * 7 + 3);
        mem[14'h2005] = 8'hA7;
        rst = 1;
        idle_inputs();
`ifdef VRAM_ARB_STATS_EN
        stat_clr = 0;
`endif
        test_reset();
        test_cpu_read();
        test_render_vs_cpu();
        test_loader_burst();
        test_render_steal();
        test_reset_mid_burst();
`ifdef VRAM_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares the single PPU VRAM port (pattern/nametable/palette memory behind the PPU memory wrapper) among three requesters:
  - PPU background/sprite renderer.
  - CPU-side PPUDATA ($2007) accesses.
  - A bulk CHR/nametable loader used at game select.
- Sits between the PPU, the loader and the VRAM memory wrapper. Runs on the PPU clock.
- Renderer has absolute priority. CPU and loader share leftover slots under a bounded-burst round-robin policy.

Parameters:
- ADDR_W, 14, VRAM address width.
- DATA_W, 8, VRAM data width.
- LOADER_BURST, 16, max consecutive loader grants before the CPU gets a turn (range 1..255).

Ports:
- clk  in  1  PPU clock
- rst  in  1  reset; one clock; synchronous, active-high
- r_req  in  1  renderer request; r_addr in ADDR_W; renderer is read-only
- r_gnt  out  1  renderer access issued this cycle
- r_rvalid  out  1  renderer read data valid on rdata
- c_req, c_we  in  1,1  CPU request, write enable
- c_addr  in  ADDR_W  CPU address
- c_wdata  in  DATA_W  CPU write data
- c_gnt  out  1  CPU access issued this cycle
- c_rvalid  out  1  CPU read data valid on rdata
- l_req, l_we  in  1,1  loader request, write enable
- l_addr  in  ADDR_W  loader address
- l_wdata  in  DATA_W  loader write data
- l_gnt, l_rvalid  out  1,1  loader grant / read data valid
- rdata  out  DATA_W  shared read-return bus; pass-through of mem_rdata
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; 1-cycle latency after address

Behaviour:
- Handshake:
  - Requester holds req, addr, we and wdata stable until it sees gnt high at a rising edge.
  - The gnt cycle is the issue cycle. mem_* are driven combinationally from the winner in that cycle.
  - For reads, *_rvalid is registered high exactly one cycle after gnt, with rdata = mem_rdata.
  - Writes produce no rvalid.
- At most one gnt per cycle.
- No winner: mem_we=0, mem_addr=0, mem_wdata=0.
- mem_we = winner's we; the renderer's we is forced 0.
- Priority 1: r_req wins unconditionally, in any state. This does not change FSM state or burst count.
- When r_req=0, the FSM decides:
  - IDLE:
    - l_req and (last_owner==CPU or !c_req): grant loader, cnt<=1, go BURST.
    - else if c_req: grant CPU, last_owner<=CPU, stay IDLE.
  - BURST:
    - l_req and cnt<LOADER_BURST: grant loader, cnt<=cnt+1.
    - otherwise (l_req dropped or cnt==LOADER_BURST): last_owner<=LOADER, go IDLE. No grant this cycle; the CPU wins in IDLE next free cycle.
- Burst cycles stolen by the renderer do not increment cnt. The CPU waits during BURST.
- LOADER_BURST=1 degenerates to strict alternation.
- cnt is 8 bits and never wraps; it is bounded by LOADER_BURST.
- Reset:
  - All gnt/rvalid = 0, state IDLE, cnt=0, last_owner=LOADER, so the CPU wins the first tie.
  - rvalid for a read issued in the cycle rst asserts is dropped.
- Simultaneous c_req and l_req on the first cycle after reset: CPU wins.
- A request raised in the same cycle as another requester's gnt is evaluated next cycle.

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- Defined: adds outputs stat_stall_cpu [15:0] and stat_stall_ldr [15:0], and input stat_clr [1].
  - Each counter counts cycles where that requester had req=1 and no gnt.
  - Counters saturate at 16'hFFFF.
  - Cleared by rst or stat_clr. stat_clr takes priority over increment in the same cycle.
- Undefined: ports and counters are absent. Arbitration is identical.

Test Plan:
- CPU read only: c_req=1, c_addr=14'h2005, mem returns 8'hA7 -> c_gnt at cycle 0, c_rvalid=1 and rdata=8'hA7 at cycle 1, mem_we=0.
- Renderer vs CPU: r_req and c_req held together for 3 cycles, then r_req drops -> r_gnt for 3 cycles, c_gnt on cycle 3, no double grants.
- Loader burst: LOADER_BURST=4, l_req and c_req both held continuously from reset:
  - c_gnt first.
  - Then 4 l_gnt, writing 14'h0000..0003 with mem_we=1.
  - Then 1 gap cycle, then c_gnt, then the next burst.
- Renderer steal in burst: r_req pulses 2 cycles mid-burst -> loader still gets exactly 4 grants; r_gnt cycles excluded from the count.
- Reset mid-burst: rst asserted after 2 loader grants with a CPU read just granted -> next cycle all gnt/rvalid=0, state IDLE; after release, CPU wins the tie.
- Stats (VRAM_ARB_STATS_EN): CPU blocked 5 cycles by the renderer -> stat_stall_cpu=5; stat_clr -> 0 next cycle; a 70000-cycle block -> 16'hFFFF.
